// File: rtl/tile_cfg_pkg.sv
// Shared types and defaults for the tile bl/wl configuration loader.
// Holds the FSM state encoding and the beat/counter sizing helpers.
package tile_cfg_pkg;

    localparam int DEF_NUM_BL   = 40;
    localparam int DEF_NUM_WL   = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_WL_PULSE = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Number of cfg_data beats needed to fill one row of bit lines.
    function automatic int beats_per_row(input int num_bl, input int data_w);
        return num_bl / data_w;
    endfunction

    // Counter width for a counter spanning 0..n-1, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bl_shadow_reg.sv
// Chunk-indexed shadow register collecting one row of bit-line data.
// Each write lands in the next DATA_W slice; the beat index wraps per row.
module bl_shadow_reg
    import tile_cfg_pkg::*;
#(
    parameter int NUM_BL = DEF_NUM_BL,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [NUM_BL-1:0] row_o,
    output logic              last_beat_o
);

    localparam int BEATS = beats_per_row(NUM_BL, DATA_W);
    localparam int BW    = cnt_w(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic [NUM_BL-1:0] row_q, row_d;
    logic [BW-1:0]     beat_q, beat_d;

    // Merge the incoming beat into its slice and advance the beat index.
    always_comb begin
        row_d  = row_q;
        beat_d = beat_q;
        if (wr_en_i) begin
            row_d[int'(beat_q) * DATA_W +: DATA_W] = data_i;
            beat_d = (beat_q == LAST) ? '0 : beat_q + 1'b1;
        end
    end

    // Shadow contents and beat index; reset restarts the row at slice 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            row_q  <= '0;
            beat_q <= '0;
        end else begin
            row_q  <= row_d;
            beat_q <= beat_d;
        end
    end

    // Write-through view: includes the beat being written this cycle, so
    // the top can register the completed row on the same edge.
    assign row_o       = row_d;
    assign last_beat_o = (beat_q == LAST);

endmodule

// File: rtl/tile_bl_wl_loader.sv
// Streams a chunked bitstream into one tiled bank column, row by row:
// load NUM_BL bits, present them on bl_out, pulse one wl_out bit, advance.
module tile_bl_wl_loader
    import tile_cfg_pkg::*;
#(
    parameter int NUM_BL   = DEF_NUM_BL,
    parameter int NUM_WL   = DEF_NUM_WL,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WL_PULSE = DEF_WL_PULSE
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [NUM_BL-1:0] bl_out,
    output logic [NUM_WL-1:0] wl_out,
    output logic              busy,
    output logic              done
);

    localparam int RW = cnt_w(NUM_WL);
    localparam int PW = cnt_w(WL_PULSE);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_WL - 1);
    localparam logic [PW-1:0] PLS_LAST = PW'(WL_PULSE - 1);

    if ((NUM_BL % DATA_W) != 0 || WL_PULSE < 1) begin : g_bad_cfg
        $error("tile_bl_wl_loader: NUM_BL must be a multiple of DATA_W and WL_PULSE >= 1");
    end

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [NUM_BL-1:0] bl_q, bl_d;
    logic [NUM_WL-1:0] wl_q, wl_d;

    logic              xfer;
    logic              last_beat;
    logic [NUM_BL-1:0] shadow;

    assign xfer = cfg_valid & ready_q;

    bl_shadow_reg #(
        .NUM_BL (NUM_BL),
        .DATA_W (DATA_W)
    ) u_shadow (
        .clk_i       (prog_clk),
        .rst_ni      (prog_reset_n),
        .wr_en_i     (xfer),
        .data_i      (cfg_data),
        .row_o       (shadow),
        .last_beat_o (last_beat)
    );

    // Sequencing: load a row, settle, pulse the word line, hold, advance.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        pcnt_d  = pcnt_q;
        done_d  = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                    done_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (xfer && last_beat) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                pcnt_d  = '0;
            end
            ST_PULSE: begin
                if (pcnt_q == PLS_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (row_q == ROW_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    row_d   = row_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so every output is a flop.
    always_comb begin
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d == ST_LOAD)  || (state_d == ST_SETUP) ||
                  (state_d == ST_PULSE) || (state_d == ST_HOLD);
        bl_d    = '0;
        wl_d    = '0;
        if ((state_d == ST_SETUP) || (state_d == ST_PULSE) ||
            (state_d == ST_HOLD)) begin
            bl_d = shadow;
        end
        if (state_d == ST_PULSE) begin
            wl_d = NUM_WL'(1) << row_d;
        end
    end

    // State, counters and registered outputs; reset aborts any pass.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            bl_q    <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bl_out    = bl_q;
    assign wl_out    = wl_q;

endmodule

// File: tb/tb_tile_bl_wl_loader.sv
// Self-checking bench for tile_bl_wl_loader: a per-row timeline model for
// the default build plus directed checks on a 16x1 single-beat build.
module tb_tile_bl_wl_loader;

    localparam int NBL = 40;
    localparam int NWL = 4;
    localparam int DW  = 8;
    localparam int WP  = 2;
    localparam int BPR = NBL / DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           start;
    logic [DW-1:0]  cfg_data;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [NBL-1:0] bl_out;
    logic [NWL-1:0] wl_out;
    logic           busy;
    logic           done;

    logic           start6;
    logic [15:0]    data6;
    logic           valid6;
    logic           ready6;
    logic [15:0]    bl6;
    logic [0:0]     wl6;
    logic           busy6;
    logic           done6;

    tile_bl_wl_loader #(
        .NUM_BL(NBL), .NUM_WL(NWL), .DATA_W(DW), .WL_PULSE(WP)
    ) dut (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .bl_out(bl_out), .wl_out(wl_out), .busy(busy), .done(done)
    );

    tile_bl_wl_loader #(
        .NUM_BL(16), .NUM_WL(1), .DATA_W(16), .WL_PULSE(1)
    ) dut6 (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start6),
        .cfg_data(data6), .cfg_valid(valid6), .cfg_ready(ready6),
        .bl_out(bl6), .wl_out(wl6), .busy(busy6), .done(done6)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Model: mode 0 idle, 1 loading beats, 2 row presented (k = cycles since
    // the row completed), 3 the single cycle after the last row.
    int             m_mode, m_beat, m_row, m_k;
    logic           m_done, m_xfer;
    logic [NBL-1:0] m_shadow;

    always @(posedge clk) begin
        m_xfer = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_beat = 0; m_row = 0; m_k = 0;
            m_done = 1'b0; m_shadow = '0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_beat = 0; m_row = 0; m_done = 1'b0;
                end
                1: if (cfg_valid) begin
                    m_xfer = 1'b1;
                    m_shadow[m_beat*DW +: DW] = cfg_data;
                    m_beat++;
                    if (m_beat == BPR) begin
                        m_beat = 0; m_mode = 2; m_k = 0;
                    end
                end
                2: if (m_k == WP + 1) begin
                    if (m_row == NWL - 1) begin
                        m_mode = 3; m_done = 1'b1;
                    end else begin
                        m_row++; m_mode = 1;
                    end
                end else begin
                    m_k++;
                end
                default: m_mode = 0;
            endcase
        end
    end

    logic           chk_en = 1'b0;
    logic [NBL-1:0] prev_bl = '0;

    always @(negedge clk) begin : cmp
        logic [NBL-1:0] e_bl;
        logic [NWL-1:0] e_wl;
        if (chk_en) begin
            e_bl = (m_mode == 2) ? m_shadow : '0;
            e_wl = (m_mode == 2 && m_k >= 1 && m_k <= WP) ?
                   (NWL'(1) << m_row) : '0;
            check("m_ready", cfg_ready, (m_mode == 1));
            check("m_busy", busy, (m_mode == 1 || m_mode == 2));
            check("m_done", done, m_done);
            check("m_bl", bl_out, e_bl);
            check("m_wl", wl_out, e_wl);
            check("wl_onehot0", $onehot0(wl_out), 1);
            if (wl_out != '0) check("bl_stable_under_wl", bl_out, prev_bl);
            if (bl_out != '0) check("bl_only_when_row", busy && !cfg_ready, 1);
            prev_bl = bl_out;
        end
    end

    int nb = 0;
    int drop_at = -1;
    int drop_cnt = 0;

    // One cycle: wait for the sampling edge, then present the next beat.
    task automatic step();
        @(negedge clk);
        if (m_xfer) begin
            nb++;
            cfg_data = DW'(nb + 1);
            if (nb == drop_at) begin
                cfg_valid = 1'b0;
                drop_cnt = 3;
            end
            if (nb == BPR * NWL) cfg_valid = 1'b0;
        end else if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) cfg_valid = 1'b1;
        end
    endtask

    task automatic run_pass(input string tag, input int drop, input int sa,
                            input int sb, input int sc, input int abort_row,
                            input int exp_n);
        int n, d_n, rises, wl0_len;
        logic seen, pdone;
        nb = 0; drop_at = drop; drop_cnt = 0;
        cfg_data = 8'h01; cfg_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " done_clr"}, done, 0);
        check({tag, " busy_go"}, busy, 1);
        n = 0; d_n = -1; rises = 0; wl0_len = 0;
        seen = 1'b0; pdone = done;
        while (n < exp_n + 6) begin
            step();
            n++;
            start = (n == sa) || (n == sb) || (n == sc);
            if (drop_cnt > 0) begin
                check({tag, " stall_ready"}, cfg_ready, 1);
                check({tag, " stall_wl"}, wl_out, 0);
            end
            if (wl_out == 4'b0001) begin
                wl0_len++;
                if (!seen) check({tag, " row0_bl"}, bl_out, 40'h0504030201);
                seen = 1'b1;
            end
            if (abort_row >= 0 && wl_out == 4'(1 << abort_row)) begin
                start = 1'b0;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check({tag, " rst_bl"}, bl_out, 0);
                check({tag, " rst_wl"}, wl_out, 0);
                check({tag, " rst_busy"}, busy, 0);
                check({tag, " rst_done"}, done, 0);
                check({tag, " rst_ready"}, cfg_ready, 0);
                return;
            end
            if (done && !pdone) begin
                rises++;
                if (d_n < 0) d_n = n;
            end
            pdone = done;
        end
        start = 1'b0;
        check({tag, " done_cycle"}, d_n, exp_n);
        check({tag, " done_rises"}, rises, 1);
        check({tag, " wl0_len"}, wl0_len, WP);
        check({tag, " end_busy"}, busy, 0);
        check({tag, " end_done"}, done, 1);
        check({tag, " end_bl"}, bl_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        start6 = 1'b0; valid6 = 1'b0; data6 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_bl", bl_out, 0);
        check("reset_wl", wl_out, 0);
        check("reset_ready", cfg_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset6_done", done6, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_pass("t1", -1, -1, -1, -1, -1, 36);
        repeat (3) @(negedge clk);
        run_pass("t2", 7, -1, -1, -1, -1, 39);
        repeat (3) @(negedge clk);
        run_pass("t3", -1, 2, 6, 36, -1, 36);
        repeat (3) @(negedge clk);
        run_pass("t4a", -1, -1, -1, -1, 2, 36);
        run_pass("t4b", -1, -1, -1, -1, -1, 36);
        repeat (3) @(negedge clk);

        start6 = 1'b1; valid6 = 1'b1; data6 = 16'hBEEF;
        @(negedge clk);
        start6 = 1'b0;
        check("t6 c0_ready", ready6, 1);
        check("t6 c0_bl", bl6, 0);
        @(negedge clk);
        valid6 = 1'b0;
        check("t6 c1_bl", bl6, 16'hBEEF);
        check("t6 c1_wl", wl6, 0);
        @(negedge clk);
        check("t6 c2_wl", wl6, 1);
        check("t6 c2_bl", bl6, 16'hBEEF);
        @(negedge clk);
        check("t6 c3_wl", wl6, 0);
        check("t6 c3_done", done6, 0);
        @(negedge clk);
        check("t6 c4_done", done6, 1);
        check("t6 c4_busy", busy6, 0);
        check("t6 c4_bl", bl6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
